// File: rtl/input_pulse_conditioner.sv
// Raw input conditioner: synchronizer, debounce FSM with qualification counter,
// and registered one-cycle press pulse plus debounced level.
module input_pulse_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic pulse_out,
    output logic level_out
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLow,
        StRiseChk,
        StHigh,
        StFallChk
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   level_q, level_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StLow;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    // Counter is cleared on every state change, so it only ever counts
    // consecutive confirming samples within one check state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        unique case (state_q)
            StLow: begin
                if (sync_in) begin
                    state_d = StRiseChk;
                    cnt_d   = '0;
                end
            end
            StRiseChk: begin
                if (!sync_in) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (!sync_in) begin
                    state_d = StFallChk;
                    cnt_d   = '0;
                end
            end
            StFallChk: begin
                if (sync_in) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign pulse_out = pulse_q;
    assign level_out = level_q;

endmodule
